seq_frame_tx: RTL and testbench
===============================

SEQ_FRAME_TX -- requirements
Module: seq_frame_tx

Interface
REQ-001 Parameter DATA_W, default 8: payload width in bits.
REQ-002 Parameter PREAMBLE, default 5'b10110: sync pattern sent before each payload.
REQ-003 Parameter PREAMBLE_W, default 5: preamble width in bits.
REQ-004 Parameter IDLE_GAP, default 2: cycles with valid=0 after each frame; range 0..15.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 reset  input  1  reset; synchronous, active-high.
REQ-007 data_in  input  DATA_W  payload word; sampled on accept.
REQ-008 data_valid  input  1  payload word available.
REQ-009 data_ready  output  1  block can accept a word this cycle.
REQ-010 tx_en  input  1  transmit enable; 0 pauses the bit stream.
REQ-011 seq  output  1  serial bit to the downstream sequence detector.
REQ-012 valid  output  1  seq is meaningful this cycle.
REQ-013 busy  output  1  frame in progress: PREAMBLE, PAYLOAD or GAP state.
REQ-014 frame_done  output  1  one-cycle pulse on the last payload bit.

Function
REQ-015 The FSM SHALL have the states ST_IDLE, ST_PREAMBLE, ST_PAYLOAD and ST_GAP, plus a bit counter and a DATA_W shift register.
REQ-016 data_ready SHALL be 1 only in ST_IDLE; data_valid in any other state SHALL be ignored and SHALL NOT be captured.
REQ-017 Accept SHALL occur on an edge where data_valid=1 and data_ready=1: data_in is captured, the counter is cleared and the FSM goes to ST_PREAMBLE.
REQ-018 The first preamble bit SHALL appear on seq with valid=1 in the cycle after accept, provided tx_en=1 (one-cycle latency).
REQ-019 ST_PREAMBLE SHALL emit PREAMBLE MSB-first, one bit per tx_en=1 cycle, then go to ST_PAYLOAD.
REQ-020 ST_PAYLOAD SHALL emit the captured word MSB-first, one bit per tx_en=1 cycle.
REQ-021 frame_done SHALL be 1 in the same cycle the last payload bit is on seq with valid=1, and 0 in every other cycle.
REQ-022 After the last payload bit, the FSM SHALL go to ST_GAP if IDLE_GAP>0, else directly to ST_IDLE.
REQ-023 ST_GAP SHALL last exactly IDLE_GAP cycles regardless of tx_en, with valid=0 and seq=0, then go to ST_IDLE.
REQ-024 While tx_en=0 in ST_PREAMBLE or ST_PAYLOAD: valid=0, seq holds its last value, and the counter and shift register hold.
REQ-025 On tx_en returning to 1, transmission SHALL resume with the next untransmitted bit; no bit is skipped or repeated.
REQ-026 In ST_IDLE, valid=0 and seq=0.
REQ-027 seq, valid and frame_done SHALL be driven from registers (no combinational path from inputs).
REQ-028 Each frame SHALL be exactly PREAMBLE_W+DATA_W valid bits; payload bits are not escaped, and payload emulation of PREAMBLE is out of scope.

Reset
REQ-029 reset=1 SHALL on the next edge force ST_IDLE and clear the counter and shift register.
REQ-030 reset SHALL force seq=0, valid=0, frame_done=0 and busy=0; data_ready=1 from the first cycle after reset deasserts.
REQ-031 Reset mid-frame SHALL abort the frame with no further valid bits, and no frame_done for it.
REQ-032 Reset SHALL take priority over accept and over tx_en.

Verification
REQ-033 Single frame: defaults, tx_en=1, data_in=0xA5 accepted at cycle 0 -> expected output:
  - cycles 1-5: seq=1,0,1,1,0 with valid=1;
  - cycles 6-13: seq=1,0,1,0,0,1,0,1 with valid=1;
  - cycle 13: frame_done=1;
  - cycles 14-15: valid=0;
  - cycle 16: data_ready=1.
REQ-034 Pause: tx_en=0 for 3 cycles after the 2nd preamble bit of a 0xFF frame -> 3 cycles with valid=0 and seq held at 0; then bits 1,1,0 then 0xFF; 13 valid bits total.
REQ-035 Busy ignore: data_valid=1 held with data_in changing throughout a frame -> only the word at the accept edge is sent; the next accept occurs only at the first ST_IDLE cycle.
REQ-036 Reset mid-payload: reset=1 during the 4th payload bit -> valid=0 from the next cycle, no frame_done, data_ready=1 the cycle after reset deasserts.
REQ-037 Loopback: output feeds a 10110 sequence detector, IDLE_GAP=0, back-to-back frames 0x00 and 0x3C -> exactly one detection per preamble, and each frame starts 2 cycles after the previous frame_done (ST_IDLE, then accept).

Source files
------------

// File: rtl/seq_frame_tx_if.sv
// seq_frame_tx_if - bundle of the payload handshake and serial stream signals
// of seq_frame_tx.
//   data_in / data_valid / data_ready : payload word handshake
//   tx_en                             : pauses the serial stream when 0
//   seq / valid                       : serial bit and its qualifier
//   busy / frame_done                 : frame status
// master: the side feeding words and consuming the stream.
// slave : the transmitter itself.
interface seq_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;
    logic              tx_en;
    logic              seq;
    logic              valid;
    logic              busy;
    logic              frame_done;

    modport master (
        output data_in, data_valid, tx_en,
        input  data_ready, seq, valid, busy, frame_done
    );

    modport slave (
        input  data_in, data_valid, tx_en,
        output data_ready, seq, valid, busy, frame_done
    );
endinterface

// File: rtl/seq_frame_tx.sv
// seq_frame_tx - serial frame transmitter.
// Accepts one DATA_W word when idle and sends PREAMBLE then the word, both
// MSB-first, one bit per tx_en=1 cycle, followed by IDLE_GAP quiet cycles.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : seq_frame_tx_if.slave (handshake, tx_en, seq/valid, busy, frame_done)
// seq, valid and frame_done come straight from flops. The first bit is
// launched on the accept edge itself, so it appears one cycle after accept.
module seq_frame_tx #(
    parameter int                    DATA_W     = 8,
    parameter int                    PREAMBLE_W = 5,
    parameter logic [PREAMBLE_W-1:0] PREAMBLE   = 5'b10110,
    parameter int                    IDLE_GAP   = 2
) (
    input logic           clk,
    input logic           reset,
    seq_frame_tx_if.slave bus
);
    localparam int CNT_MAX = (DATA_W > PREAMBLE_W)
                             ? ((DATA_W > IDLE_GAP) ? DATA_W : IDLE_GAP)
                             : ((PREAMBLE_W > IDLE_GAP) ? PREAMBLE_W : IDLE_GAP);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_PAYLOAD,
        ST_GAP
    } state_e;

    state_e                  state_q, state_d;
    // PREAMBLE/PAYLOAD: bits already sent in that phase; GAP: gap cycles spent
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0]       shift_q, shift_d;
    logic [PREAMBLE_W-1:0]   pre_q, pre_d;
    logic                    seq_q, seq_d;
    logic                    valid_q, valid_d;
    logic                    done_q, done_d;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            pre_q   <= '0;
            seq_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            pre_q   <= pre_d;
            seq_q   <= seq_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        pre_d   = pre_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.data_valid) begin
                    state_d = ST_PREAMBLE;
                    cnt_d   = '0;
                    shift_d = bus.data_in;
                    pre_d   = PREAMBLE;
                    // Preamble bit 0 goes out on this same edge when enabled
                    if (bus.tx_en) begin
                        pre_d = PREAMBLE << 1;
                        if (PREAMBLE_W == 1) state_d = ST_PAYLOAD;
                        else                 cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_PREAMBLE: begin
                if (bus.tx_en) begin
                    pre_d = pre_q << 1;
                    if (cnt_q == CNT_W'(PREAMBLE_W - 1)) begin
                        state_d = ST_PAYLOAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_PAYLOAD: begin
                // cnt_q==DATA_W: the last bit is on the wire this cycle
                if (cnt_q == CNT_W'(DATA_W)) begin
                    state_d = (IDLE_GAP > 0) ? ST_GAP : ST_IDLE;
                    cnt_d   = '0;
                end else if (bus.tx_en) begin
                    shift_d = shift_q << 1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(IDLE_GAP - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: next values of the registered stream outputs
    always_comb begin
        seq_d   = seq_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                seq_d = 1'b0;
                if (bus.data_valid && bus.tx_en) begin
                    seq_d   = PREAMBLE[PREAMBLE_W-1];
                    valid_d = 1'b1;
                end
            end
            ST_PREAMBLE: begin
                if (bus.tx_en) begin
                    seq_d   = pre_q[PREAMBLE_W-1];
                    valid_d = 1'b1;
                end
            end
            ST_PAYLOAD: begin
                if (cnt_q == CNT_W'(DATA_W)) begin
                    seq_d = 1'b0;
                end else if (bus.tx_en) begin
                    seq_d   = shift_q[DATA_W-1];
                    valid_d = 1'b1;
                    done_d  = (cnt_q == CNT_W'(DATA_W - 1));
                end
            end
            default: seq_d = 1'b0;
        endcase
    end

    assign bus.data_ready = (state_q == ST_IDLE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.seq        = seq_q;
    assign bus.valid      = valid_q;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_seq_frame_tx.sv
// tb_seq_frame_tx - directed checks of seq_frame_tx: single frame with a busy
// input, tx_en pause, reset mid-payload, and a back-to-back loopback into a
// 10110 detector with IDLE_GAP=0.
module tb_seq_frame_tx;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    seq_frame_tx_if #(.DATA_W(8)) b0 ();
    seq_frame_tx_if #(.DATA_W(8)) b1 ();

    seq_frame_tx #(.DATA_W(8), .PREAMBLE_W(5), .PREAMBLE(5'b10110), .IDLE_GAP(2))
        u_dut (.clk(clk), .reset(reset), .bus(b0));
    seq_frame_tx #(.DATA_W(8), .PREAMBLE_W(5), .PREAMBLE(5'b10110), .IDLE_GAP(0))
        u_lb (.clk(clk), .reset(reset), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 10110 detector on the valid bits of the loopback instance
    logic [4:0] det_sh = '0;
    int         det_cnt = 0;
    always @(posedge clk) begin
        if (b1.valid) begin
            det_sh <= {det_sh[3:0], b1.seq};
            if ({det_sh[3:0], b1.seq} == 5'b10110) det_cnt <= det_cnt + 1;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [12:0] exp_a5;
    logic [10:0] exp_ff_tail;
    int          vcnt;
    int          done1, done2, start2;

    initial begin
        n_chk = 0;
        n_err = 0;
        exp_a5      = 13'b10110_10100101;
        exp_ff_tail = 11'b110_11111111;
        reset = 1'b1;
        b0.data_in = '0; b0.data_valid = 1'b0; b0.tx_en = 1'b1;
        b1.data_in = '0; b1.data_valid = 1'b0; b1.tx_en = 1'b1;
        repeat (2) step();
        chk("rst_valid", int'(b0.valid), 0);
        chk("rst_seq",   int'(b0.seq), 0);
        chk("rst_done",  int'(b0.frame_done), 0);
        chk("rst_busy",  int'(b0.busy), 0);
        reset = 1'b0;
        step();
        chk("rst_ready", int'(b0.data_ready), 1);

        // Frame 0xA5, data_valid held with data_in changing while busy
        b0.data_in = 8'hA5; b0.data_valid = 1'b1;
        step();
        for (int c = 1; c <= 13; c++) begin
            chk("a5_valid", int'(b0.valid), 1);
            chk("a5_seq",   int'(b0.seq), int'(exp_a5[13-c]));
            chk("a5_done",  int'(b0.frame_done), int'(c == 13));
            chk("a5_ready", int'(b0.data_ready), 0);
            b0.data_in = 8'(c * 37 + 3);
            step();
        end
        for (int c = 14; c <= 15; c++) begin
            chk("gap_valid", int'(b0.valid), 0);
            chk("gap_seq",   int'(b0.seq), 0);
            chk("gap_busy",  int'(b0.busy), 1);
            chk("gap_ready", int'(b0.data_ready), 0);
            step();
        end
        chk("c16_ready", int'(b0.data_ready), 1);
        chk("c16_valid", int'(b0.valid), 0);

        // 0xFF frame accepted at the first idle cycle, paused after 2 bits
        b0.data_in = 8'hFF;
        step();
        vcnt = 0;
        chk("ff_b0_valid", int'(b0.valid), 1);
        chk("ff_b0_seq",   int'(b0.seq), 1);
        vcnt += int'(b0.valid);
        b0.data_valid = 1'b0;
        step();
        chk("ff_b1_valid", int'(b0.valid), 1);
        chk("ff_b1_seq",   int'(b0.seq), 0);
        vcnt += int'(b0.valid);
        b0.tx_en = 1'b0;
        step();
        for (int p = 0; p < 3; p++) begin
            chk("pause_valid", int'(b0.valid), 0);
            chk("pause_seq",   int'(b0.seq), 0);
            chk("pause_busy",  int'(b0.busy), 1);
            if (p == 2) b0.tx_en = 1'b1;
            step();
        end
        for (int i = 10; i >= 0; i--) begin
            chk("ff_valid", int'(b0.valid), 1);
            chk("ff_seq",   int'(b0.seq), int'(exp_ff_tail[i]));
            chk("ff_done",  int'(b0.frame_done), int'(i == 0));
            vcnt += int'(b0.valid);
            step();
        end
        chk("ff_total_bits", vcnt, 13);
        chk("ff_gap_valid", int'(b0.valid), 0);
        step();
        step();
        chk("ff_idle_ready", int'(b0.data_ready), 1);

        // 0x5A frame, reset during the 4th payload bit with data_valid high
        b0.data_in = 8'h5A; b0.data_valid = 1'b1;
        step();
        b0.data_valid = 1'b0;
        repeat (8) step();
        chk("p4_valid", int'(b0.valid), 1);
        chk("p4_seq",   int'(b0.seq), 1);
        reset = 1'b1;
        b0.data_valid = 1'b1;
        step();
        chk("rmid_valid", int'(b0.valid), 0);
        chk("rmid_busy",  int'(b0.busy), 0);
        chk("rmid_done",  int'(b0.frame_done), 0);
        b0.data_valid = 1'b0;
        reset = 1'b0;
        step();
        chk("rmid_ready", int'(b0.data_ready), 1);
        for (int i = 0; i < 6; i++) begin
            chk("rmid_quiet_valid", int'(b0.valid), 0);
            chk("rmid_quiet_done",  int'(b0.frame_done), 0);
            step();
        end

        // Loopback: back-to-back 0x00 and 0x3C with IDLE_GAP=0
        b1.data_in = 8'h00; b1.data_valid = 1'b1;
        step();
        vcnt = 0; done1 = 0; done2 = 0; start2 = 0;
        for (int c = 1; c <= 28; c++) begin
            vcnt += int'(b1.valid);
            if (b1.frame_done) begin
                if (done1 == 0) done1 = c;
                else            done2 = c;
            end
            if (b1.valid && done1 != 0 && c > done1 && start2 == 0) start2 = c;
            if (c == 14) chk("lb_idle_ready", int'(b1.data_ready), 1);
            if (c == 2)  b1.data_in = 8'h3C;
            if (c == 15) b1.data_valid = 1'b0;
            step();
        end
        chk("lb_done1", done1, 13);
        chk("lb_done2", done2, 27);
        chk("lb_start_gap", start2 - done1, 2);
        chk("lb_bits", vcnt, 26);
        chk("lb_detections", det_cnt, 2);
        chk("lb_end_ready", int'(b1.data_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
